// File: rtl/operand_fwd_ctrl_if.sv
// Decode-side request and forwarding-control response bundle for operand_fwd_ctrl.
// master = pipeline decode/issue logic, slave = the forwarding controller.
interface operand_fwd_ctrl_if #(
    parameter int unsigned RAW = 5
);
    logic           id_valid;
    logic [RAW-1:0] id_rs;
    logic [RAW-1:0] id_rt;
    logic           id_use_rs;
    logic           id_use_rt;
    logic           id_alt_a;
    logic           id_alt_b;
    logic [RAW-1:0] id_rd;
    logic           id_we;
    logic           id_is_load;
    logic           flush;
    logic [1:0]     sel_a;
    logic [1:0]     sel_b;
    logic           stall;
    logic           ex_valid;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_alt_a, id_alt_b,
               id_rd, id_we, id_is_load, flush,
        input  sel_a, sel_b, stall, ex_valid
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_alt_a, id_alt_b,
               id_rd, id_we, id_is_load, flush,
        output sel_a, sel_b, stall, ex_valid
    );
endinterface

// File: rtl/operand_fwd_ctrl.sv
// Operand forwarding / load-use hazard controller: tracks EX and MEM producers,
// registers ALU operand select codes aligned with EX, and raises a load-use stall.
module operand_fwd_ctrl #(
    parameter int unsigned RAW = 5
) (
    input  logic               clk,
    input  logic               reset,
    operand_fwd_ctrl_if.slave  bus
);
    localparam int unsigned SW = 2;

    localparam logic [SW-1:0] SEL_RF  = SW'(0);
    localparam logic [SW-1:0] SEL_EX  = SW'(1);
    localparam logic [SW-1:0] SEL_MEM = SW'(2);
    localparam logic [SW-1:0] SEL_ALT = SW'(3);

    // EX and MEM producer records. The WB record is not kept: its data reaches
    // the operand through the register-file path, so nothing here would read it.
    logic           ex_valid_q;
    logic [RAW-1:0] ex_rd_q;
    logic           ex_we_q;
    logic           ex_load_q;
    logic           mem_valid_q;
    logic [RAW-1:0] mem_rd_q;
    logic           mem_we_q;

    logic [SW-1:0]  sel_a_q;
    logic [SW-1:0]  sel_b_q;

    logic [SW-1:0]  sel_a_c;
    logic [SW-1:0]  sel_b_c;
    logic           stall_c;
    logic           bubble_c;

    function automatic logic [SW-1:0] pick_sel(
        input logic           use_src,
        input logic [RAW-1:0] src,
        input logic           alt,
        input logic           ex_fwd_ok,
        input logic [RAW-1:0] ex_rd,
        input logic           mem_fwd_ok,
        input logic [RAW-1:0] mem_rd
    );
        logic [SW-1:0] sel;
        sel = SEL_RF;
        if (alt) begin
            sel = SEL_ALT;
        end else if (use_src && (src != RAW'(0))) begin
            // newer producer in EX wins over the older one in MEM
            if (ex_fwd_ok && (src == ex_rd)) begin
                sel = SEL_EX;
            end else if (mem_fwd_ok && (src == mem_rd)) begin
                sel = SEL_MEM;
            end
        end
        return sel;
    endfunction

    // Select codes for the instruction in ID and load-use hazard detection
    always_comb begin
        logic ex_fwd_ok;
        logic mem_fwd_ok;
        logic hit_a;
        logic hit_b;

        ex_fwd_ok  = ex_valid_q && ex_we_q;
        mem_fwd_ok = mem_valid_q && mem_we_q;

        sel_a_c = pick_sel(bus.id_use_rs, bus.id_rs, bus.id_alt_a,
                           ex_fwd_ok, ex_rd_q, mem_fwd_ok, mem_rd_q);
        sel_b_c = pick_sel(bus.id_use_rt, bus.id_rt, bus.id_alt_b,
                           ex_fwd_ok, ex_rd_q, mem_fwd_ok, mem_rd_q);

        hit_a = bus.id_use_rs && (bus.id_rs == ex_rd_q) && !bus.id_alt_a;
        hit_b = bus.id_use_rt && (bus.id_rt == ex_rd_q) && !bus.id_alt_b;

        stall_c = bus.id_valid && ex_fwd_ok && ex_load_q &&
                  (ex_rd_q != RAW'(0)) && (hit_a || hit_b) && !bus.flush;

        bubble_c = bus.flush || stall_c;
    end

    // Pipeline record shift and registered selects
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            ex_we_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= '0;
            mem_we_q    <= 1'b0;
            sel_a_q     <= SEL_RF;
            sel_b_q     <= SEL_RF;
        end else begin
            mem_valid_q <= ex_valid_q;
            mem_rd_q    <= ex_rd_q;
            mem_we_q    <= ex_we_q;
            if (bubble_c) begin
                ex_valid_q <= 1'b0;
                ex_rd_q    <= '0;
                ex_we_q    <= 1'b0;
                ex_load_q  <= 1'b0;
                sel_a_q    <= SEL_RF;
                sel_b_q    <= SEL_RF;
            end else begin
                ex_valid_q <= bus.id_valid;
                ex_rd_q    <= bus.id_valid ? bus.id_rd : RAW'(0);
                ex_we_q    <= bus.id_valid && bus.id_we;
                ex_load_q  <= bus.id_valid && bus.id_is_load;
                sel_a_q    <= sel_a_c;
                sel_b_q    <= sel_b_c;
            end
        end
    end

    assign bus.sel_a    = sel_a_q;
    assign bus.sel_b    = sel_b_q;
    assign bus.stall    = stall_c;
    assign bus.ex_valid = ex_valid_q;
endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Self-checking bench for operand_fwd_ctrl: directed hazard scenarios plus
// randomized instruction streams compared against an in-flight instruction list model.
module tb_operand_fwd_ctrl;
    localparam int unsigned RAW = 5;

    logic clk;
    logic reset;

    operand_fwd_ctrl_if #(.RAW(RAW)) bus ();

    operand_fwd_ctrl #(.RAW(RAW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // Reference model: list of instructions in flight, index 0 = EX, 1 = MEM
    typedef struct {
        bit v;
        int rd;
        bit we;
        bit ld;
    } rec_t;
    rec_t pipe[$];
    bit   last_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit producer(input int idx, input int src);
        if (pipe.size() <= idx) return 1'b0;
        return pipe[idx].v && pipe[idx].we && (pipe[idx].rd == src);
    endfunction

    function automatic int model_sel(input bit use_src, input int src, input bit alt);
        if (alt) return 3;
        if (!use_src || src == 0) return 0;
        if (producer(0, src)) return 1;
        if (producer(1, src)) return 2;
        return 0;
    endfunction

    function automatic bit model_stall();
        bit dep;
        if (!bus.id_valid || bus.flush || pipe.size() == 0) return 1'b0;
        if (!(pipe[0].v && pipe[0].we && pipe[0].ld && pipe[0].rd != 0)) return 1'b0;
        dep = (bus.id_use_rs && int'(bus.id_rs) == pipe[0].rd && !bus.id_alt_a) ||
              (bus.id_use_rt && int'(bus.id_rt) == pipe[0].rd && !bus.id_alt_b);
        return dep;
    endfunction

    task automatic set_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                          input bit aa, input bit ab, input int rd, input bit we, input bit ld,
                          input bit fl);
        bus.id_valid   = v;
        bus.id_rs      = RAW'(rs);
        bus.id_rt      = RAW'(rt);
        bus.id_use_rs  = urs;
        bus.id_use_rt  = urt;
        bus.id_alt_a   = aa;
        bus.id_alt_b   = ab;
        bus.id_rd      = RAW'(rd);
        bus.id_we      = we;
        bus.id_is_load = ld;
        bus.flush      = fl;
    endtask

    // One cycle: inputs already driven after a negedge; check stall, clock, check EX outputs
    task automatic step(input string tag);
        bit   exp_stall;
        int   exp_a;
        int   exp_b;
        rec_t nr;
        #1;
        exp_stall = model_stall();
        check({tag, ".stall"}, 32'(bus.stall), 32'(exp_stall));
        exp_a = model_sel(bus.id_use_rs, int'(bus.id_rs), bus.id_alt_a);
        exp_b = model_sel(bus.id_use_rt, int'(bus.id_rt), bus.id_alt_b);
        if (bus.flush || exp_stall) begin
            nr = '{v: 1'b0, rd: 0, we: 1'b0, ld: 1'b0};
            exp_a = 0;
            exp_b = 0;
        end else begin
            nr = '{v: bus.id_valid, rd: int'(bus.id_rd),
                   we: bus.id_valid && bus.id_we, ld: bus.id_valid && bus.id_is_load};
        end
        @(posedge clk);
        #1;
        pipe.push_front(nr);
        while (pipe.size() > 2) void'(pipe.pop_back());
        last_stall = exp_stall;
        check({tag, ".ex_valid"}, 32'(bus.ex_valid), 32'(nr.v));
        check({tag, ".sel_a"}, 32'(bus.sel_a), 32'(exp_a));
        check({tag, ".sel_b"}, 32'(bus.sel_b), 32'(exp_b));
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pipe.delete();
        last_stall = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        check("rst.sel_a", 32'(bus.sel_a), 32'd0);
        check("rst.sel_b", 32'(bus.sel_b), 32'd0);
        check("rst.ex_valid", 32'(bus.ex_valid), 32'd0);
        check("rst.stall", 32'(bus.stall), 32'd0);

        // EX forward
        set_id(1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0); step("exf.add");
        set_id(1, 3, 4, 1, 1, 0, 0, 5, 1, 0, 0); step("exf.sub");
        check("exf.sel_a_is_1", 32'(bus.sel_a), 32'd1);

        // MEM forward, then EX-over-MEM priority
        set_id(1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0); step("memf.w3");
        set_id(1, 8, 9, 1, 1, 0, 0, 6, 1, 0, 0); step("memf.unrel");
        set_id(1, 3, 0, 1, 0, 0, 0, 7, 1, 0, 0); step("memf.use");
        check("memf.sel_a_is_2", 32'(bus.sel_a), 32'd2);
        set_id(1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0); step("prio.w3a");
        set_id(1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0); step("prio.w3b");
        set_id(1, 3, 0, 1, 0, 0, 0, 9, 1, 0, 0); step("prio.use");
        check("prio.sel_a_is_1", 32'(bus.sel_a), 32'd1);

        // Load-use: one stall cycle, bubble, then MEM forward
        set_id(1, 0, 0, 0, 0, 0, 0, 7, 1, 1, 0); step("lu.load");
        set_id(1, 1, 7, 1, 1, 0, 0, 10, 1, 0, 0); step("lu.stall");
        check("lu.bubble", 32'(bus.ex_valid), 32'd0);
        step("lu.retry");
        check("lu.sel_b_is_2", 32'(bus.sel_b), 32'd2);

        // r0 never forwarded; alternate operand wins and avoids a stall
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step("r0.w0");
        set_id(1, 0, 0, 1, 0, 0, 0, 4, 1, 0, 0); step("r0.use");
        check("r0.sel_a_is_0", 32'(bus.sel_a), 32'd0);
        set_id(1, 0, 0, 0, 0, 0, 0, 4, 1, 1, 0); step("alt.load");
        set_id(1, 0, 4, 0, 1, 0, 1, 11, 1, 0, 0); step("alt.use");
        check("alt.sel_b_is_3", 32'(bus.sel_b), 32'd3);

        // Flush kills the consumer and suppresses the stall
        set_id(1, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0); step("fl.load");
        set_id(1, 2, 2, 1, 1, 0, 0, 12, 1, 0, 1); step("fl.use");
        check("fl.ex_valid_is_0", 32'(bus.ex_valid), 32'd0);

        // Randomized streams over a small register pool to provoke hazards
        for (int i = 0; i < 600; i++) begin
            if (!last_stall) begin
                set_id($urandom_range(0, 9) != 0,
                       $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 3), $urandom_range(0, 4) != 0,
                       $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0);
            end
            step("rnd");
        end

        // Async reset mid-stream with a load to r5 in EX and a dependent op in ID
        set_id(1, 0, 0, 0, 0, 1, 0, 5, 1, 1, 0); step("ar.load");
        set_id(1, 5, 0, 1, 0, 0, 0, 6, 1, 0, 0);
        #1;
        check("ar.pre_stall", 32'(bus.stall), 32'd1);
        check("ar.pre_sel_a", 32'(bus.sel_a), 32'd3);
        #1;
        reset = 1'b1;
        #1;
        check("ar.sel_a", 32'(bus.sel_a), 32'd0);
        check("ar.sel_b", 32'(bus.sel_b), 32'd0);
        check("ar.ex_valid", 32'(bus.ex_valid), 32'd0);
        check("ar.stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        do_reset();
        set_id(1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0); step("ar.after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
